// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory access sequencer (mem_access_ctrl).
package mem_ctrl_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester, MAR and memory-port signals of mem_access_ctrl.
// master = CPU/memory environment side, slave = the sequencer itself.
interface mem_access_ctrl_if import mem_ctrl_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic [DW-1:0] f_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;

  logic          mar_en;
  logic [AW-1:0] mar_addr;

  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  f_gnt, f_rdata, d_gnt, d_rdata, mar_en, mar_addr,
           mem_req, mem_we, mem_wdata, err
  );

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output f_gnt, f_rdata, d_gnt, d_rdata, mar_en, mar_addr,
           mem_req, mem_we, mem_wdata, err
  );

endinterface

// File: rtl/mem_access_ctrl_arb.sv
// Two-input round-robin arbiter: on a tie the requester not served last wins.
module rr_arbiter2 import mem_ctrl_pkg::*; (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   req_f,
  input  logic   req_d,
  output owner_t owner
);

  owner_t last_owner;

  always_comb begin
    owner = OWN_FETCH;
    if (req_f && req_d) begin
      owner = (last_owner == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (req_d) begin
      owner = OWN_DATA;
    end
  end

  // Resetting to DATA hands the first tie after reset to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_DATA;
    end else if (en) begin
      last_owner <= owner;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the MAR and memory port between fetch and data requesters (IDLE/LOAD/ACCESS/DONE).
// Define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without mem_ready.
module mem_access_ctrl import mem_ctrl_pkg::*; #(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus
);

  state_t        state;
  state_t        next_state;
  owner_t        owner;
  owner_t        win_owner;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;

  logic          any_req;
  logic          start;
  logic          timed_out;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] read_value;

  logic          f_gnt_d;
  logic          d_gnt_d;
  logic          mar_en_d;
  logic          mem_req_d;
  logic          mem_we_d;
  logic          err_d;
  logic [DW-1:0] f_rdata_d;
  logic [DW-1:0] d_rdata_d;
  logic [DW-1:0] mem_wdata_d;
  logic [AW-1:0] mar_addr_d;

  assign any_req = bus.f_req | bus.d_req;
  assign start   = (state == IDLE) && any_req;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (start),
    .req_f (bus.f_req),
    .req_d (bus.d_req),
    .owner (win_owner)
  );

  assign sel_addr  = (win_owner == OWN_FETCH) ? bus.f_addr : bus.d_addr;
  assign sel_we    = (win_owner == OWN_DATA) && bus.d_we;
  assign sel_wdata = (win_owner == OWN_DATA) ? bus.d_wdata : '0;

  // Writes return zero data; so does a timed-out access since mem_ready is low.
  assign read_value = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Cleared during LOAD so it starts at zero on the first ACCESS cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == LOAD) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !bus.mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == ACCESS) && !bus.mem_ready &&
                     (wait_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = LOAD;
      LOAD:    next_state = ACCESS;
      ACCESS:  if (bus.mem_ready || timed_out) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= OWN_FETCH;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (start) begin
      owner   <= win_owner;
      addr_q  <= sel_addr;
      we_q    <= sel_we;
      wdata_q <= sel_wdata;
    end
  end

  // Outputs are decoded from the upcoming state and registered below,
  // so each one is visible in the cycle its state is entered.
  always_comb begin
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_rdata_d   = '0;
    d_rdata_d   = '0;
    mar_en_d    = 1'b0;
    mar_addr_d  = '0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    err_d       = 1'b0;
    case (next_state)
      LOAD: begin
        mar_en_d   = 1'b1;
        mar_addr_d = sel_addr;
      end
      ACCESS: begin
        mem_req_d   = 1'b1;
        mem_we_d    = we_q;
        mem_wdata_d = wdata_q;
      end
      DONE: begin
        err_d = timed_out;
        if (owner == OWN_FETCH) begin
          f_gnt_d   = 1'b1;
          f_rdata_d = read_value;
        end else begin
          d_gnt_d   = 1'b1;
          d_rdata_d = read_value;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.f_gnt     <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.f_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mar_en    <= 1'b0;
      bus.mar_addr  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.err       <= 1'b0;
    end else begin
      bus.f_gnt     <= f_gnt_d;
      bus.d_gnt     <= d_gnt_d;
      bus.f_rdata   <= f_rdata_d;
      bus.d_rdata   <= d_rdata_d;
      bus.mar_en    <= mar_en_d;
      bus.mar_addr  <= mar_addr_d;
      bus.mem_req   <= mem_req_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_wdata <= mem_wdata_d;
      bus.err       <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; timeout scenarios follow MEM_TIMEOUT_EN.
module tb_mem_access_ctrl;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.f_req     = 1'b0;
    bus.f_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.mar_en, bus.mem_req, bus.mem_we, bus.err} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bus.f_gnt, bus.d_gnt, bus.mar_en, bus.mem_req, bus.mem_we, bus.err});
    end
    checks++;
    if ({bus.f_rdata, bus.d_rdata, bus.mar_addr, bus.mem_wdata} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0",
               {bus.f_rdata, bus.d_rdata, bus.mar_addr, bus.mem_wdata});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.mar_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_no_req mar_en: got %b expected 0", bus.mar_en);
    end
  endtask

  task automatic test_fetch_read();
    bus.f_req     = 1'b1;
    bus.f_addr    = 16'h1234;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    checks++;
    if ({bus.mar_en, bus.mar_addr, bus.mem_req} !== {1'b1, 16'h1234, 1'b0}) begin
      failures++;
      $display("[TB] FAIL fetch_c1 mar_en/mar_addr/mem_req: got %b/%h/%b expected 1/1234/0",
               bus.mar_en, bus.mar_addr, bus.mem_req);
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mar_en} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL fetch_c2 mem_req/mem_we/mar_en: got %b%b%b expected 100",
               bus.mem_req, bus.mem_we, bus.mar_en);
    end
    tick();
    checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.mem_req, bus.err} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL fetch_c3 f_gnt/d_gnt/mem_req/err: got %b%b%b%b expected 1000",
               bus.f_gnt, bus.d_gnt, bus.mem_req, bus.err);
    end
    checks++;
    if (bus.f_rdata !== 16'hBEEF) begin
      failures++;
      $display("[TB] FAIL fetch_rdata: got %h expected beef", bus.f_rdata);
    end
    bus.f_req = 1'b0;
    tick();
    checks++;
    if ({bus.f_gnt, bus.f_rdata} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL fetch_c4 gnt cleared: got %b/%h expected 0/0", bus.f_gnt, bus.f_rdata);
    end
  endtask

  task automatic test_write_wait();
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b1;
    bus.d_addr    = 16'h00FF;
    bus.d_wdata   = 16'hA5A5;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h1111;
    tick();
    checks++;
    if ({bus.mar_en, bus.mar_addr} !== {1'b1, 16'h00FF}) begin
      failures++;
      $display("[TB] FAIL write_c1 mar_en/mar_addr: got %b/%h expected 1/00ff", bus.mar_en, bus.mar_addr);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) bus.mem_ready = 1'b1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wdata, bus.d_gnt} !== {1'b1, 1'b1, 16'hA5A5, 1'b0}) begin
        failures++;
        $display("[TB] FAIL write_access c%0d mem_req/mem_we/mem_wdata/d_gnt: got %b/%b/%h/%b expected 1/1/a5a5/0",
                 c, bus.mem_req, bus.mem_we, bus.mem_wdata, bus.d_gnt);
      end
    end
    tick();
    checks++;
    if ({bus.d_gnt, bus.f_gnt, bus.mem_req, bus.d_rdata} !== {3'b100, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL write_c6 d_gnt/f_gnt/mem_req/d_rdata: got %b/%b/%b/%h expected 1/0/0/0000",
               bus.d_gnt, bus.f_gnt, bus.mem_req, bus.d_rdata);
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    tick();
    checks++;
    if (bus.d_gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_c7 d_gnt: got %b expected 0", bus.d_gnt);
    end
  endtask

  task automatic test_back_to_back();
    bus.f_req     = 1'b1;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.f_addr    = 16'h2000;
    bus.d_addr    = 16'h3000;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic          exp_fetch;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      exp_fetch     = (k % 2 == 0);
      exp_addr      = exp_fetch ? 16'h2000 : 16'h3000;
      exp_data      = 16'h5A00 + 16'(k);
      bus.mem_rdata = exp_data;
      tick();
      checks++;
      if ({bus.mar_en, bus.mar_addr} !== {1'b1, exp_addr}) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] mar_en/mar_addr: got %b/%h expected 1/%h", k, bus.mar_en, bus.mar_addr, exp_addr);
      end
      tick();
      checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b10) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] mem_req/mem_we: got %b%b expected 10", k, bus.mem_req, bus.mem_we);
      end
      tick();
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== {exp_fetch, !exp_fetch}) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] owner f_gnt/d_gnt: got %b%b expected %b%b",
                 k, bus.f_gnt, bus.d_gnt, exp_fetch, !exp_fetch);
      end
      checks++;
      if (exp_fetch ? ({bus.f_rdata, bus.d_rdata} !== {exp_data, 16'h0})
                    : ({bus.d_rdata, bus.f_rdata} !== {exp_data, 16'h0})) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] rdata f/d: got %h/%h expected owner data %h", k, bus.f_rdata, bus.d_rdata, exp_data);
      end
      if (k == 3) begin
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
      end
      tick();
      checks++;
      if ({bus.f_gnt, bus.d_gnt} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] gnt after done: got %b%b expected 00", k, bus.f_gnt, bus.d_gnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.f_req     = 1'b1;
    bus.f_addr    = 16'h4444;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid in access mem_req: got %b expected 1", bus.mem_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.mar_en, bus.mem_req, bus.mem_we, bus.err} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid ctrl: got %b expected 000000",
               {bus.f_gnt, bus.d_gnt, bus.mar_en, bus.mem_req, bus.mem_we, bus.err});
    end
    checks++;
    if ({bus.f_rdata, bus.d_rdata, bus.mar_addr, bus.mem_wdata} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL rst_mid data: got %h expected 0",
               {bus.f_rdata, bus.d_rdata, bus.mar_addr, bus.mem_wdata});
    end
    bus.f_req     = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.f_gnt, bus.mem_req, bus.mar_en} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL rst_mid dropped f_gnt/mem_req/mar_en: got %b%b%b expected 000",
               bus.f_gnt, bus.mem_req, bus.mar_en);
    end
    bus.f_req     = 1'b1;
    bus.d_req     = 1'b1;
    bus.f_addr    = 16'h5555;
    bus.d_addr    = 16'h6666;
    bus.mem_rdata = 16'h0F0F;
    tick();
    checks++;
    if (bus.mar_addr !== 16'h5555) begin
      failures++;
      $display("[TB] FAIL rst_mid restart mar_addr: got %h expected 5555", bus.mar_addr);
    end
    tick();
    tick();
    checks++;
    if ({bus.f_gnt, bus.d_gnt, bus.f_rdata} !== {2'b10, 16'h0F0F}) begin
      failures++;
      $display("[TB] FAIL rst_mid restart f_gnt/d_gnt/f_rdata: got %b%b/%h expected 10/0f0f",
               bus.f_gnt, bus.d_gnt, bus.f_rdata);
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    bit got;
    hi  = 0;
    got = 1'b0;
    bus.f_req     = 1'b1;
    bus.f_addr    = 16'h7000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h9999;
    tick();
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (bus.mem_req === 1'b1) hi++;
      if (bus.f_gnt === 1'b1) got = 1'b1;
    end
    checks++;
    if (got !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout gnt within 40 cycles: got %b expected 1", got);
    end
    checks++;
    if (hi != TIMEOUT) begin
      failures++;
      $display("[TB] FAIL timeout mem_req cycles: got %0d expected %0d", hi, TIMEOUT);
    end
    checks++;
    if ({bus.err, bus.f_rdata, bus.mem_req} !== {1'b1, 16'h0000, 1'b0}) begin
      failures++;
      $display("[TB] FAIL timeout err/f_rdata/mem_req: got %b/%h/%b expected 1/0000/0",
               bus.err, bus.f_rdata, bus.mem_req);
    end
    bus.f_req = 1'b0;
    tick();
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout err pulse: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_ready_on_limit();
    bus.f_req     = 1'b1;
    bus.f_addr    = 16'h7100;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h7777;
    tick();
    for (int c = 2; c <= 16; c++) begin
      tick();
      if (c == 16) bus.mem_ready = 1'b1;
    end
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL limit c16 mem_req: got %b expected 1", bus.mem_req);
    end
    tick();
    checks++;
    if ({bus.f_gnt, bus.err, bus.f_rdata} !== {2'b10, 16'h7777}) begin
      failures++;
      $display("[TB] FAIL limit f_gnt/err/f_rdata: got %b/%b/%h expected 1/0/7777",
               bus.f_gnt, bus.err, bus.f_rdata);
    end
    bus.f_req = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    int hi;
    hi = 0;
    bus.f_req     = 1'b1;
    bus.f_addr    = 16'h7000;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h7777;
    tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.mem_req === 1'b1 && bus.f_gnt === 1'b0 && bus.err === 1'b0) hi++;
    end
    checks++;
    if (hi != 100) begin
      failures++;
      $display("[TB] FAIL no_timeout waiting cycles: got %0d expected 100", hi);
    end
    bus.mem_ready = 1'b1;
    tick();
    checks++;
    if ({bus.f_gnt, bus.err, bus.f_rdata} !== {2'b10, 16'h7777}) begin
      failures++;
      $display("[TB] FAIL no_timeout completion f_gnt/err/f_rdata: got %b/%b/%h expected 1/0/7777",
               bus.f_gnt, bus.err, bus.f_rdata);
    end
    bus.f_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_read();
    test_write_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
    test_ready_on_limit();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
